perceptron_n: RTL and testbench

Parametrised N-input perceptron, the successor to the fixed 4-input perceptron. It holds N signed weights, N signed inputs and a programmable bias in registers loaded over a write port. On `start` it accumulates one weight×input product per cycle, then applies a run-time-selected activation function. It sits beside the existing perceptron in the tiny-net datapath, one instance per neuron, and is sequenced by the layer controller through a start/done handshake.

---
 rtl/perceptron_pkg.sv | 56 +++++
 rtl/perceptron_mac_unit.sv | 49 ++++
 rtl/perceptron_n.sv | 165 ++++++++++++++++
 tb/tb_perceptron_n.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : perceptron_pkg                                          |
// | Description : Shared types and helpers for the N-input perceptron:   |
// |               activation-mode enum, FSM state enum and a signed      |
// |               saturating add.                                         |
// | Revision    : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
package perceptron_pkg;

  typedef enum logic [1:0] {
    MODE_STEP  = 2'd0,
    MODE_RELU  = 2'd1,
    MODE_SIGN  = 2'd2,
    MODE_IDENT = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_ACT  = 2'd2
  } state_t;

  // Result of a saturating add: clipped sum plus a flag that clipping happened.
  typedef struct packed {
    logic               clip;
    logic signed [63:0] sum;
  } sat_res_t;

  // Adds two sign-extended operands and clips the result into the signed
  // range of a 'width'-bit register. Operands must already fit in 'width' bits,
  // so the 64-bit intermediate sum can never overflow for width <= 62.
  function automatic sat_res_t sat_add(input logic signed [63:0] a,
                                       input logic signed [63:0] b,
                                       input int unsigned        width);
    sat_res_t           res;
    logic signed [63:0] s;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    s        = a + b;
    hi       = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo       = -(64'sd1 <<< (width - 1));
    res.clip = 1'b0;
    res.sum  = s;
    if (s > hi) begin
      res.sum  = hi;
      res.clip = 1'b1;
    end else if (s < lo) begin
      res.sum  = lo;
      res.clip = 1'b1;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/perceptron_mac_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : perceptron_mac_unit                                     |
// | Description : Combinational multiply-accumulate step. Forms the full  |
// |               2*BW signed product, sign-extends it to ACCW and adds   |
// |               it to the running accumulator. With PERCEPTRON_SAT_EN   |
// |               defined the add saturates and reports clipping;         |
// |               otherwise it wraps and clip is always 0.                |
// | Revision    : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module perceptron_mac_unit
  import perceptron_pkg::*;
#(
  parameter int BW   = 8,
  parameter int ACCW = 24
) (
  input  logic signed [BW-1:0]   w,
  input  logic signed [BW-1:0]   x,
  input  logic signed [ACCW-1:0] acc_in,
  output logic signed [ACCW-1:0] acc_next,
  output logic                   clip
);

  logic signed [2*BW-1:0] prod;
  logic signed [ACCW-1:0] prod_ext;

  // Full-precision signed product, then sign extension into the accumulator width.
  assign prod     = w * x;
  assign prod_ext = ACCW'(prod);

`ifdef PERCEPTRON_SAT_EN
  sat_res_t sat;

  // Saturating add: clip into the representable accumulator range.
  always_comb begin
    sat      = sat_add(64'(acc_in), 64'(prod_ext), ACCW);
    acc_next = ACCW'(sat.sum);
    clip     = sat.clip;
  end
`else
  // Wrap-around add modulo 2^ACCW; never reports clipping.
  always_comb begin
    acc_next = acc_in + prod_ext;
    clip     = 1'b0;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/perceptron_n.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : perceptron_n                                            |
// | Description : N-input perceptron. Weight/input banks and bias are     |
// |               loaded through a write port while idle; start runs N    |
// |               multiply-accumulate cycles followed by one activation   |
// |               cycle, then pulses done. Build macro PERCEPTRON_SAT_EN  |
// |               selects saturating accumulation and enables ovf;        |
// |               without it the accumulator wraps and ovf stays 0.       |
// | Revision    : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module perceptron_n
  import perceptron_pkg::*;
#(
  parameter int N    = 8,
  parameter int BW   = 8,
  parameter int ACCW = 24,
  parameter int AW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   wr_sel,
  input  logic [AW-1:0]          wr_addr,
  input  logic [BW-1:0]          wr_data,
  input  logic                   bias_we,
  input  logic [ACCW-1:0]        bias_in,
  input  logic [1:0]             mode,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   fire,
  output logic [ACCW-1:0]        act_out,
  output logic                   ovf
);

  state_t                 state;
  state_t                 next_state;
  mode_t                  mode_q;
  logic signed [BW-1:0]   w_bank [N];
  logic signed [BW-1:0]   x_bank [N];
  logic signed [ACCW-1:0] bias_q;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] acc_next;
  logic [AW-1:0]          idx;
  logic                   idx_last;
  logic                   clip;
  logic                   acc_load;
  logic                   acc_step;
  logic                   act_en;
  logic                   wr_ok;
  logic                   acc_nonneg;
  logic [ACCW-1:0]        act_val;

  assign busy     = (state != S_IDLE);
  assign idx_last = (idx == AW'(N - 1));
  // Writes are only accepted while idle and for in-range addresses.
  assign wr_ok    = wr_en && !busy && ({1'b0, wr_addr} < (AW + 1)'(N));

  perceptron_mac_unit #(
    .BW   (BW),
    .ACCW (ACCW)
  ) u_mac (
    .w        (w_bank[idx]),
    .x        (x_bank[idx]),
    .acc_in   (acc),
    .acc_next (acc_next),
    .clip     (clip)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic and per-state datapath strobes.
  always_comb begin
    next_state = state;
    acc_load   = 1'b0;
    acc_step   = 1'b0;
    act_en     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          acc_load   = 1'b1;
          next_state = S_ACC;
        end
      end
      S_ACC: begin
        acc_step = 1'b1;
        if (idx_last) next_state = S_ACT;
      end
      S_ACT: begin
        act_en     = 1'b1;
        next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Activation function applied to the final sum, selected by the latched mode.
  always_comb begin
    acc_nonneg = ~acc[ACCW-1];
    act_val    = '0;
    unique case (mode_q)
      MODE_STEP:  act_val = {{(ACCW-1){1'b0}}, acc_nonneg};
      MODE_RELU:  act_val = acc_nonneg ? acc : '0;
      MODE_SIGN:  act_val = acc_nonneg ? ACCW'(1) : '1;
      MODE_IDENT: act_val = acc;
      default:    act_val = '0;
    endcase
  end

  // Weight and input register banks.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        w_bank[k] <= '0;
        x_bank[k] <= '0;
      end
    end else if (wr_ok) begin
      if (wr_sel) x_bank[wr_addr] <= wr_data;
      else        w_bank[wr_addr] <= wr_data;
    end
  end

  // Bias register; a write on the start edge lands after acc has taken the old value.
  always_ff @(posedge clk) begin
    if (rst)                  bias_q <= '0;
    else if (bias_we && !busy) bias_q <= bias_in;
  end

  // Accumulator, index, mode latch, overflow flag and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      idx     <= '0;
      mode_q  <= MODE_STEP;
      ovf     <= 1'b0;
      fire    <= 1'b0;
      act_out <= '0;
      done    <= 1'b0;
    end else begin
      done <= act_en;
      if (acc_load) begin
        acc    <= bias_q;
        idx    <= '0;
        mode_q <= mode_t'(mode);
        ovf    <= 1'b0;
      end
      if (acc_step) begin
        acc <= acc_next;
        idx <= idx + AW'(1);
        if (clip) ovf <= 1'b1;
      end
      if (act_en) begin
        fire    <= acc_nonneg;
        act_out <= act_val;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_perceptron_n.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_perceptron_n                                         |
// | Description : Directed self-checking bench for perceptron_n with      |
// |               N=4, BW=8, ACCW=16. Expected values are hand-computed;  |
// |               PERCEPTRON_SAT_EN selects the saturating expectations.  |
// | Revision    : 1.0  initial release                                    |
// +----------------------------------------------------------------------+
module tb_perceptron_n;

  localparam int N    = 4;
  localparam int BW   = 8;
  localparam int ACCW = 16;
  localparam int AW   = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_en;
  logic            wr_sel;
  logic [AW-1:0]   wr_addr;
  logic [BW-1:0]   wr_data;
  logic            bias_we;
  logic [ACCW-1:0] bias_in;
  logic [1:0]      mode;
  logic            start;
  logic            busy;
  logic            done;
  logic            fire;
  logic [ACCW-1:0] act_out;
  logic            ovf;

  int checks = 0;
  int errors = 0;

  perceptron_n #(
    .N    (N),
    .BW   (BW),
    .ACCW (ACCW),
    .AW   (AW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .bias_we (bias_we),
    .bias_in (bias_in),
    .mode    (mode),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .fire    (fire),
    .act_out (act_out),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic sel, input int addr, input int val);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_addr = AW'(addr);
    wr_data = BW'(val);
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic load4(input int w0, w1, w2, w3, input int xv);
    write_reg(1'b0, 0, w0);
    write_reg(1'b0, 1, w1);
    write_reg(1'b0, 2, w2);
    write_reg(1'b0, 3, w3);
    for (int k = 0; k < N; k++) write_reg(1'b1, k, xv);
  endtask

  task automatic write_bias(input int val);
    @(negedge clk);
    bias_we = 1'b1;
    bias_in = ACCW'(val);
    @(negedge clk);
    bias_we = 1'b0;
  endtask

  // One evaluation: start in cycle 0, busy over 1..N+1, done in N+2.
  // inj: attempt weight/bias writes while busy. sb: bias write on the start edge.
  task automatic run(input string tag, input logic [1:0] m, input logic [15:0] exp_act,
                     input logic exp_fire, input logic exp_ovf, input bit inj,
                     input bit sb, input int sbv);
    int bad;
    bad = 0;
    @(negedge clk);
    mode  = m;
    start = 1'b1;
    if (sb) begin
      bias_we = 1'b1;
      bias_in = ACCW'(sbv);
    end
    for (int c = 1; c <= N + 1; c++) begin
      @(negedge clk);
      start   = 1'b0;
      bias_we = 1'b0;
      wr_en   = 1'b0;
      if (busy !== 1'b1 || done !== 1'b0) bad++;
      if (inj && c == 2) begin
        wr_en   = 1'b1;
        wr_sel  = 1'b0;
        wr_addr = '0;
        wr_data = 8'd9;
        bias_we = 1'b1;
        bias_in = 16'd50;
      end
    end
    @(negedge clk);
    wr_en   = 1'b0;
    bias_we = 1'b0;
    check({tag, "_busy_window"}, 32'(bad), 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_act"}, 32'(act_out), 32'(exp_act));
    check({tag, "_fire"}, {31'd0, fire}, {31'd0, exp_fire});
    check({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
  endtask

  initial begin
    int bad;
    bit seen_done;
    rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
    bias_we = 1'b0; bias_in = '0; mode = 2'd0; start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_fire", {31'd0, fire}, 32'd0);
    check("rst_ovf",  {31'd0, ovf},  32'd0);
    check("rst_act",  32'(act_out),  32'd0);

    // Weights 1..4, inputs 1, bias 0: sum 10, step -> 1.
    load4(1, 2, 3, 4, 1);
    run("step", 2'd0, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // Weights -1..-4, inputs 1, bias 5: sum -5.
    load4(-1, -2, -3, -4, 1);
    write_bias(5);
    run("relu_neg",  2'd1, 16'd0,     1'b0, 1'b0, 1'b0, 1'b0, 0);
    run("sign_neg",  2'd2, 16'hFFFF,  1'b0, 1'b0, 1'b0, 1'b0, 0);
    run("ident_neg", 2'd3, 16'hFFFB,  1'b0, 1'b0, 1'b0, 1'b0, 0);

    // All 127, bias 0: true sum 64516.
    load4(127, 127, 127, 127, 127);
    write_bias(0);
`ifdef PERCEPTRON_SAT_EN
    run("big", 2'd3, 16'd32767, 1'b1, 1'b1, 1'b0, 1'b0, 0);
`else
    run("big", 2'd3, 16'hFC04,  1'b0, 1'b0, 1'b0, 1'b0, 0);
`endif

    // Writes while busy are ignored, in this run and the next.
    load4(1, 2, 3, 4, 1);
    run("busy_wr",     2'd3, 16'd10, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    run("busy_wr_re",  2'd3, 16'd10, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // Bias written on the start edge: old bias used now, new bias next time.
    run("bias_edge",    2'd3, 16'd10,  1'b1, 1'b0, 1'b0, 1'b1, 100);
    run("bias_edge_re", 2'd3, 16'd110, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    // Start held high across done: done at N+2 and 2N+4 only.
    bad = 0;
    @(negedge clk);
    mode  = 2'd3;
    start = 1'b1;
    for (int c = 1; c <= 2 * N + 4; c++) begin
      @(negedge clk);
      if (done !== ((c == N + 2) || (c == 2 * N + 4))) bad++;
      if (busy !== !((c == N + 2) || (c == 2 * N + 4))) bad++;
    end
    start = 1'b0;
    check("b2b_pattern", 32'(bad), 32'd0);
    check("b2b_act", 32'(act_out), 32'd110);

    // Reset mid-evaluation aborts and clears everything.
    write_bias(7);
    @(negedge clk);
    mode  = 2'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_act",  32'(act_out),  32'd0);
    check("mid_rst_fire", {31'd0, fire}, 32'd0);
    seen_done = 1'b0;
    for (int c = 0; c < N + 4; c++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    check("mid_rst_no_done", {31'd0, seen_done}, 32'd0);
    for (int k = 0; k < N; k++) write_reg(1'b1, k, 1);
    run("post_rst", 2'd3, 16'd0, 1'b1, 1'b0, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
